fib_pair_serializer: RTL and testbench
======================================

Name: fib_pair_serializer

Overview:
Downstream consumer of the double-rate Fibonacci generator. It accepts the generator's pair of numbers per transfer (earlier number on in_lo, later on in_hi) over a valid/ready handshake. It emits them one per cycle, in order, on a valid/ready output stream. An inline checker confirms that every emitted value equals the sum of the two previously emitted values (mod 2^W) and counts violations.

Parameters:
W, 16, data width of each Fibonacci number.
CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  upstream pair valid.
in_ready  output  1  block can accept a pair this cycle.
in_lo  input  W  earlier number of the pair; emitted first.
in_hi  input  W  later number of the pair; emitted second.
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  W  serialized Fibonacci number.
err_clr  input  1  clears err_flag and err_count.
err_flag  output  1  sticky; a sequence violation has been seen.
err_count  output  CNT_W  number of violations, saturating at all-ones.

Behaviour:
- Handshake: a transfer occurs on a clk edge with valid && ready on that interface. out_data and out_valid are registered and held stable while out_valid && !out_ready. in_ready is combinational from state and out_ready.
- FSM with states EMPTY, HOLD2 (both numbers held, lo at the output) and HOLD1 (only hi held, at the output). Internal regs: buf_hi (W).
- EMPTY: out_valid=0, in_ready=1. On in_valid, load out_data<=in_lo and buf_hi<=in_hi, then go to HOLD2.
- HOLD2: out_valid=1, in_ready=0. On out_ready, out_data<=buf_hi, then go to HOLD1.
- HOLD1: out_valid=1, in_ready=out_ready.
  - out_ready && in_valid: load the new pair and go to HOLD2. There are no bubbles, so output throughput is 1 number per cycle.
  - out_ready && !in_valid: go to EMPTY.
  - !out_ready: hold.
- Latency: first in transfer at cycle t gives out_valid=1 with out_data=in_lo in cycle t+1, and in_hi in the cycle after the lo transfer.
- Checker (on each out transfer): history regs p1 (last emitted), p2 (one before) and hist_cnt (0..2, saturating).
  - If hist_cnt==2 and out_data != (p1+p2) mod 2^W: set err_flag and increment err_count (saturating).
  - Then p2<=p1, p1<=out_data, hist_cnt++.
  - Addition is W bits with wrap; wraparound of the sequence is not an error.
- err_clr: clears err_flag and err_count in that cycle. If a violation occurs in the same cycle, err_clr wins for that cycle. History is not affected.
- Reset values:
  - State EMPTY; out_valid=0, out_data=0, buf_hi=0.
  - in_ready=0 during rst.
  - p1=p2=0, hist_cnt=0, err_flag=0, err_count=0.
- Reset mid-operation: held numbers are dropped, not emitted; checker history restarts. After reset the first two emitted values are never checked.
- in_lo/in_hi are ignored when no in transfer occurs.

Test Plan:
- Stream from the fibonacci_2 model (pairs {1,1},{2,3},{5,8},{13,21}) with out_ready=1 constant -> out_data 1,1,2,3,5,8,13,21 on consecutive cycles, in_ready pulses every 2nd cycle, err_flag=0.
- Same stream with out_ready toggling 1,0,1,0 -> identical order, no drops or duplicates, out_data stable while stalled, err_count=0.
- Run 30 numbers through the W=16 wrap (46368 then 75025 mod 65536 = 9489, then 55857) -> no error flagged.
- Corrupt pair {5,9} after {2,3}:
  - 5 == 2+3, so no error for 5.
  - 9 != 3+5, so err_count=1 and err_flag=1.
  - Following pair {13,21}: 13 != 5+9 → err_count=2; 21 != 9+13 → err_count=3.
  - Then pulse err_clr → err_flag=0, err_count=0.
- Assert rst while in HOLD2 holding {8,13} -> out_valid=0 the next cycle and 13 never emitted. Restart with {100,200},{300,500}: emitted 100 and 200 are unchecked, 300 and 500 pass, err_count=0.
- Force 300 consecutive bad values -> err_count saturates at 255 and holds.

Source files
------------

// File: rtl/fib_pair_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fib_pair_serializer                                                      |
// | Serializes {lo,hi} Fibonacci pairs to a 1-per-cycle stream and checks   |
// | that each emitted value is the sum of the previous two (mod 2^W).        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fib_pair_serializer #(
   parameter int W     = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_lo,
   input  logic [W-1:0]     in_hi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   input  logic             err_clr,
   output logic             err_flag,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HOLD2 = 2'd1,
      HOLD1 = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_out_valid;
   logic [W-1:0]     r_out_data;
   logic [W-1:0]     r_buf_hi;
   logic [W-1:0]     r_p1;
   logic [W-1:0]     r_p2;
   logic [1:0]       r_hist_cnt;
   logic             r_err_flag;
   logic [CNT_W-1:0] r_err_count;

   logic [W-1:0]     w_sum;
   logic             w_out_xfer;
   logic             w_viol;

   // HOLD1 can refill in the same cycle its last number leaves, so no bubbles.
   assign in_ready   = !rst && ((r_state == EMPTY) || ((r_state == HOLD1) && out_ready));
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign err_flag   = r_err_flag;
   assign err_count  = r_err_count;

   assign w_out_xfer = r_out_valid && out_ready;
   assign w_sum      = r_p1 + r_p2;
   assign w_viol     = w_out_xfer && (r_hist_cnt == 2'd2) && (r_out_data != w_sum);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_buf_hi    <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (in_valid) begin
                  r_out_data  <= in_lo;
                  r_buf_hi    <= in_hi;
                  r_out_valid <= 1'b1;
                  r_state     <= HOLD2;
               end
            end
            HOLD2: begin
               if (out_ready) begin
                  r_out_data <= r_buf_hi;
                  r_state    <= HOLD1;
               end
            end
            HOLD1: begin
               if (out_ready) begin
                  if (in_valid) begin
                     r_out_data <= in_lo;
                     r_buf_hi   <= in_hi;
                     r_state    <= HOLD2;
                  end else begin
                     r_out_valid <= 1'b0;
                     r_state     <= EMPTY;
                  end
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_p1        <= '0;
         r_p2        <= '0;
         r_hist_cnt  <= 2'd0;
         r_err_flag  <= 1'b0;
         r_err_count <= '0;
      end else begin
         if (w_out_xfer) begin
            r_p2 <= r_p1;
            r_p1 <= r_out_data;
            if (r_hist_cnt != 2'd2) begin
               r_hist_cnt <= r_hist_cnt + 2'd1;
            end
         end
         // A clear in the same cycle as a violation leaves the counters at zero.
         if (err_clr) begin
            r_err_flag  <= 1'b0;
            r_err_count <= '0;
         end else if (w_viol) begin
            r_err_flag <= 1'b1;
            if (r_err_count != {CNT_W{1'b1}}) begin
               r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fib_pair_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fib_pair_serializer                                                   |
// | Self-checking bench: directed scenarios plus randomized stream vs model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fib_pair_serializer;

   localparam int W     = 16;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_lo = '0;
   logic [W-1:0]     in_hi = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [W-1:0]     out_data;
   logic             err_clr = 1'b0;
   logic             err_flag;
   logic [CNT_W-1:0] err_count;

   fib_pair_serializer #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_lo     (in_lo),
      .in_hi     (in_hi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err_clr   (err_clr),
      .err_flag  (err_flag),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model: pairs waiting upstream, numbers accepted but not yet
   // emitted, and the emitted history since the last reset.
   logic [W-1:0] src_lo[$];
   logic [W-1:0] src_hi[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] h1, h2;
   int           hn;
   int           m_cnt;
   bit           m_flag;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      src_lo.delete();
      src_hi.delete();
      exp_q.delete();
      h1 = '0; h2 = '0; hn = 0; m_cnt = 0; m_flag = 0;
   endtask

   task automatic push_pair(input logic [W-1:0] lo, input logic [W-1:0] hi);
      src_lo.push_back(lo);
      src_hi.push_back(hi);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_lo = 16'd7; in_hi = 16'd9; out_ready = 1'b1; err_clr = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_err_flag", err_flag, 0);
      chk("post_rst_err_count", err_count, 0);
      model_clear();
   endtask

   // mode 0: out_ready=1; mode 1: out_ready toggles 1,0,...; mode 2: random everything
   task automatic run(input int mode, input int budget);
      int           cyc = 0;
      bit           tog = 1'b1;
      bit           exp_rdy, exp_ov, viol;
      logic [W-1:0] v, s;
      while ((src_lo.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         @(negedge clk);
         case (mode)
            0:       out_ready = 1'b1;
            1:       begin out_ready = tog; tog = !tog; end
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         in_valid = (src_lo.size() > 0) && (mode != 2 || $urandom_range(0, 2) != 0);
         if (in_valid) begin
            in_lo = src_lo[0]; in_hi = src_hi[0];
         end else begin
            in_lo = W'($urandom); in_hi = W'($urandom);
         end
         err_clr = (mode == 2) && ($urandom_range(0, 15) == 0);
         #1;
         exp_ov  = (exp_q.size() > 0);
         exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
         chk("in_ready", in_ready, exp_rdy);
         chk("out_valid", out_valid, exp_ov);
         if (exp_ov) chk("out_data", out_data, exp_q[0]);
         chk("err_count", err_count, m_cnt);
         chk("err_flag", err_flag, m_flag);
         viol = 1'b0;
         if (exp_ov && out_ready) begin
            v = exp_q.pop_front();
            s = h1 + h2;
            viol = (hn >= 2) && (v != s);
            h2 = h1; h1 = v; hn++;
         end
         if (err_clr) begin
            m_cnt = 0; m_flag = 0;
         end else if (viol) begin
            m_flag = 1;
            if (m_cnt < 255) m_cnt++;
         end
         if (in_valid && exp_rdy) begin
            exp_q.push_back(src_lo.pop_front());
            exp_q.push_back(src_hi.pop_front());
         end
         cyc++;
      end
      if (cyc >= budget) chk("timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
      #1;
      chk("idle_out_valid", out_valid, 0);
      chk("idle_err_count", err_count, m_cnt);
      chk("idle_err_flag", err_flag, m_flag);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      m_cnt = 0; m_flag = 0;
      chk("clr_err_flag", err_flag, 0);
      chk("clr_err_count", err_count, 0);
   endtask

   initial begin
      logic [W-1:0] a, b;
      model_clear();

      // Reset state and clean stream at full throughput
      do_reset();
      push_pair(1, 1); push_pair(2, 3); push_pair(5, 8); push_pair(13, 21);
      run(0, 200);
      chk("fib_err_flag", err_flag, 0);

      // Same stream with a stalling consumer
      do_reset();
      push_pair(1, 1); push_pair(2, 3); push_pair(5, 8); push_pair(13, 21);
      run(1, 200);
      chk("stall_err_count", err_count, 0);

      // 30 numbers through the 16-bit wrap
      do_reset();
      a = 1; b = 1;
      for (int i = 0; i < 15; i++) begin
         push_pair(a, b);
         a = a + b;
         b = a + b;
      end
      run(0, 400);
      chk("wrap_err_count", err_count, 0);
      chk("wrap_err_flag", err_flag, 0);

      // Corrupted pair: 9, 13 and 21 are violations
      do_reset();
      push_pair(1, 1); push_pair(2, 3); push_pair(5, 9); push_pair(13, 21);
      run(0, 200);
      chk("corrupt_err_count", err_count, 3);
      chk("corrupt_err_flag", err_flag, 1);
      pulse_clr();

      // Reset while holding {8,13}; restart is unchecked for its first two
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; in_lo = 16'd8; in_hi = 16'd13; out_ready = 1'b0;
      #1;
      chk("hold_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_data", out_data, 8);
      chk("hold2_in_ready", in_ready, 0);
      do_reset();
      push_pair(100, 200); push_pair(300, 500);
      run(0, 200);
      chk("restart_err_count", err_count, 0);

      // Saturation of the error counter
      do_reset();
      for (int i = 0; i < 152; i++) push_pair(1, 1);
      run(0, 1000);
      chk("sat_err_count", err_count, 255);
      push_pair(1, 1);
      run(0, 100);
      chk("sat_hold_err_count", err_count, 255);
      chk("sat_err_flag", err_flag, 1);

      // Randomized Fibonacci-like stream with occasional corruption
      do_reset();
      a = W'($urandom); b = W'($urandom);
      for (int i = 0; i < 60; i++) begin
         logic [W-1:0] lo, hi;
         lo = a; hi = b;
         if ($urandom_range(0, 7) == 0) lo = lo + 16'd1;
         if ($urandom_range(0, 7) == 0) hi = hi ^ 16'h0100;
         push_pair(lo, hi);
         a = a + b;
         b = a + b;
      end
      run(2, 3000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
